// File: rtl/fifo_burst_reader.sv
// Burst reader: drains a registered-output synchronous FIFO through a 2-entry buffer
// and tags every BURST_LEN-th delivered word with out_last.

module fifo_burst_reader_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       pop,
    input  logic [1:0] count
);
    // A capture into a full buffer is only legal when a pop frees a slot the same cycle
    property no_overflow_p;
        @(posedge clk) disable iff (rst) (capture && (count == 2'd2)) |-> pop;
    endproperty

    no_overflow_a: assert property (no_overflow_p);
endmodule

module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);
    localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] head_nx_s;
    logic [WIDTH-1:0] tail_nx_s;
    logic [1:0]       count_r;
    logic [1:0]       count_nx_s;
    logic             inflight_r;
    logic [BW-1:0]    beat_r;
    logic [BW-1:0]    beat_nx_s;
    logic             valid_r;
    logic             last_r;
    logic             pop_s;
    logic             capture_s;
    logic [2:0]       pending_s;

    assign pop_s     = valid_r & out_ready;
    assign capture_s = inflight_r;
    assign pending_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

    assign out_valid = valid_r;
    assign out_data  = head_r;
    assign out_last  = last_r;

    // Read request: issue only when the word it returns is guaranteed a free slot
    always_comb begin
        if (rst) begin
            fifo_rd_en = 1'b0;
        end else begin
            fifo_rd_en = ~fifo_empty & (pending_s < 3'd2);
        end
    end

    // Next buffer contents, occupancy and beat position
    always_comb begin
        head_nx_s  = head_r;
        tail_nx_s  = tail_r;
        count_nx_s = count_r;
        case ({capture_s, pop_s})
            2'b10: begin
                count_nx_s = count_r + 2'd1;
                if (count_r == 2'd0) begin
                    head_nx_s = fifo_rdata;
                end else begin
                    tail_nx_s = fifo_rdata;
                end
            end
            2'b01: begin
                count_nx_s = count_r - 2'd1;
                head_nx_s  = tail_r;
            end
            2'b11: begin
                if (count_r == 2'd1) begin
                    head_nx_s = fifo_rdata;
                end else begin
                    head_nx_s = tail_r;
                    tail_nx_s = fifo_rdata;
                end
            end
            default: begin
                head_nx_s  = head_r;
                tail_nx_s  = tail_r;
                count_nx_s = count_r;
            end
        endcase

        if (pop_s) begin
            if (beat_r == LAST_BEAT) begin
                beat_nx_s = {BW{1'b0}};
            end else begin
                beat_nx_s = beat_r + BW'(1'b1);
            end
        end else begin
            beat_nx_s = beat_r;
        end
    end

    // Control state; out_valid/out_last are registered from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
            beat_r     <= {BW{1'b0}};
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            count_r    <= count_nx_s;
            inflight_r <= fifo_rd_en & ~fifo_empty;
            beat_r     <= beat_nx_s;
            valid_r    <= (count_nx_s != 2'd0);
            last_r     <= (count_nx_s != 2'd0) && (beat_nx_s == LAST_BEAT);
        end
    end

    // Data slots carry no reset: their contents are ignored while count is zero
    always_ff @(posedge clk) begin
        head_r <= head_nx_s;
        tail_r <= tail_nx_s;
    end

    fifo_burst_reader_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .capture (capture_s),
        .pop     (pop_s),
        .count   (count_r)
    );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised bench: upstream FIFO model feeding fifo_burst_reader, scoreboard of
// pushed words, burst position computed from pops since the last reset.

module tb_fifo_burst_reader;
    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty, fifo_rd_en, out_valid, out_ready, out_last;
    logic [7:0] fifo_rdata, out_data;
    logic       fifo_empty2, fifo_rd_en2, out_valid2, out_ready2, out_last2;
    logic [7:0] fifo_rdata2, out_data2;

    logic [7:0] mem  [0:511];
    logic [7:0] mem2 [0:15];
    int wr_ptr = 0, rd_ptr = 0, wr2 = 0, rd2 = 0;

    int n_checks = 0, n_fail = 0;
    int exp_idx = 0, pop_cnt = 0;
    int sent, guard, start, got2;
    bit hold_pending = 1'b0;
    logic [7:0] hold_data;
    logic hold_last;

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    fifo_burst_reader #(.WIDTH(8), .BURST_LEN(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
        .fifo_rdata(fifo_rdata2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_last(out_last2)
    );

    // Upstream synchronous FIFOs: data registered one cycle after an accepted read
    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_empty2 = (rd2 == wr2);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
        if (fifo_rd_en2 && !fifo_empty2) begin
            fifo_rdata2 <= mem2[rd2];
            rd2         <= rd2 + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic step(input logic rdy);
        @(negedge clk);
        out_ready = rdy;
        #1;
        if (hold_pending) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_data", out_data, hold_data);
            check_eq("hold_last", out_last, hold_last);
        end
        if (!out_valid) check_eq("idle_last", out_last, 1'b0);
        if (out_valid && out_ready) begin
            check_eq("data", out_data, mem[exp_idx]);
            check_eq("last", out_last, (pop_cnt % 4) == 3);
            exp_idx++;
            pop_cnt++;
        end
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        hold_last    = out_last;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (((exp_idx != wr_ptr) || out_valid) && (n < budget)) begin
            step(1'b1);
            n++;
        end
        check_eq("drain_done", exp_idx == wr_ptr, 1'b1);
        check_eq("drain_idle", out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        out_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_last", out_last, 1'b0);
        check_eq("rst_rden", fifo_rd_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic stream with two-cycle first-word latency and no bubbles after
        for (int i = 1; i <= 8; i++) push(8'(i));
        step(1'b1);
        check_eq("lat_n1", out_valid, 1'b0);
        step(1'b1);
        check_eq("lat_n2", out_valid, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1);
            check_eq("thruput", out_valid, 1'b1);
        end
        drain(20);

        // Backpressure: read requests stop once two words are owed to the buffer
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        step(1'b0);
        step(1'b0);
        check_eq("bp_first", out_valid, 1'b1);
        check_eq("bp_head", out_data, 8'h30);
        check_eq("bp_rden", fifo_rd_en, 1'b0);
        repeat (4) begin
            step(1'b0);
            check_eq("bp_rden", fifo_rd_en, 1'b0);
            check_eq("bp_head", out_data, 8'h30);
        end
        drain(30);

        // Starvation mid-burst must not move the burst boundary
        push(8'h10);
        step(1'b1);
        push(8'h11);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        repeat (4) begin
            step(1'b1);
            check_eq("gap_idle", out_valid, 1'b0);
        end
        push(8'h12);
        step(1'b1);
        push(8'h13);
        drain(20);

        // Random writes and random backpressure
        sent = 0;
        guard = 0;
        while ((sent < 100) && (guard < 2000)) begin
            if ($urandom_range(1, 0) == 1) begin
                push(8'($urandom));
                sent++;
            end
            step($urandom_range(1, 0) == 1);
            guard++;
        end
        check_eq("rand_sent", sent, 100);
        drain(400);

        // Reset with two words buffered: they are lost, beat restarts at 0
        start = pop_cnt;
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        guard = 0;
        while ((pop_cnt < start + 2) && (guard < 20)) begin
            step(1'b1);
            guard++;
        end
        check_eq("pre_rst_pops", pop_cnt - start, 2);
        step(1'b0);
        step(1'b0);
        check_eq("pre_rst_full", out_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        check_eq("rst_rden_busy", fifo_rd_en, 1'b0);
        hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_valid", out_valid, 1'b0);
        check_eq("post_rst_last", out_last, 1'b0);
        exp_idx = rd_ptr;
        pop_cnt = 0;
        drain(30);

        // Two-beat bursts on the second instance
        for (int i = 0; i < 6; i++) begin
            mem2[wr2] = 8'h50 + 8'(i);
            wr2++;
        end
        got2 = 0;
        guard = 0;
        while ((got2 < 6) && (guard < 30)) begin
            @(negedge clk);
            #1;
            if (out_valid2) begin
                check_eq("bl2_data", out_data2, 8'h50 + 8'(got2));
                check_eq("bl2_last", out_last2, (got2 % 2) == 1);
                got2++;
            end
            guard++;
        end
        check_eq("bl2_count", got2, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
